// File: rtl/load_extend_ctrl_pkg.sv
// load_extend_ctrl_pkg: shared size encodings, FSM states and alignment helper for the load sequencer
package load_extend_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {IDLE, CHK, RD0, RD1, FIN} state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == SZ_HALF && off[0]) || ((size == SZ_WORD || size == SZ_DWORD) && off != 2'b00);
    endfunction

endpackage

// File: rtl/load_lane_extend.sv
// load_lane_extend: picks the little-endian byte/half lane out of a read word and sign/zero-extends it
module load_lane_extend
    import load_extend_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        signedLoad,
    output logic [31:0] q
);

    logic [7:0]  b;
    logic [15:0] h;

    // lane select then extension; word and double word pass straight through
    always_comb begin
        b = rdata[{offset, 3'b000} +: 8];
        h = rdata[{offset[1], 4'b0000} +: 16];
        q = size == SZ_BYTE ? {{24{signedLoad & b[7]}}, b} :
            size == SZ_HALF ? {{16{signedLoad & h[15]}}, h} : rdata;
    end

endmodule

// File: rtl/load_extend_ctrl.sv
// load_extend_ctrl: sequences byte/half/word/double-word loads with alignment and timeout checking
module load_extend_ctrl
    import load_extend_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [1:0]  dataSize,
    input  logic        signedLoad,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] result_lo,
    output logic [31:0] result_hi,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d, req_q, req_d;
    logic [31:0] maddr_q, maddr_d, lo_q, lo_d, hi_q, hi_d;
    logic [31:0] lane;
    logic        accept, timeout;

    assign accept  = state_q == IDLE && start;
    assign timeout = cnt_q == CNT_W'(TIMEOUT - 1);

    load_lane_extend u_lane (
        .rdata      (mem_rdata),
        .offset     (addr_q[1:0]),
        .size       (size_q),
        .signedLoad (sgn_q),
        .q          (lane)
    );

    // state and registered outputs; reset abandons any transaction in flight
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            maddr_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            req_q   <= req_d;
            maddr_q <= maddr_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    // next state: ack has priority over the timeout on the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? CHK : IDLE;
            CHK:     state_d = is_misaligned(size_q, addr_q[1:0]) ? FIN : RD0;
            RD0:     state_d = mem_ack ? (size_q == SZ_DWORD ? RD1 : FIN) : timeout ? FIN : RD0;
            RD1:     state_d = mem_ack || timeout ? FIN : RD1;
            default: state_d = IDLE;
        endcase
    end

    // next values of the registered outputs and the request/result datapath
    always_comb begin
        addr_d  = accept ? addr : addr_q;
        size_d  = accept ? dataSize : size_q;
        sgn_d   = accept ? signedLoad : sgn_q;
        cnt_d   = (state_q inside {RD0, RD1}) && state_d == state_q ? cnt_q + 1'b1 : '0;
        busy_d  = state_d inside {CHK, RD0, RD1};
        done_d  = state_d == FIN;
        err_d   = state_d == FIN && (state_q == CHK || !mem_ack);
        req_d   = state_d inside {RD0, RD1};
        maddr_d = state_q == CHK && state_d == RD0 ? {addr_q[31:2], 2'b00} :
                  state_q == RD0 && state_d == RD1 ? maddr_q + 32'(WORD_BYTES) : maddr_q;
        lo_d    = accept ? '0 : state_q == RD0 && mem_ack ? lane : lo_q;
        hi_d    = accept ? '0 : state_q == RD1 && mem_ack ? mem_rdata : hi_q;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_req   = req_q;
    assign mem_addr  = maddr_q;
    assign result_lo = lo_q;
    assign result_hi = hi_q;

endmodule
